// File: rtl/wired_lsu_oiq_pkg.sv
// Shared types for the LSU in-order issue queue: operand/entry layout and CDB rid matching.
// The entry layout fixes SRC_COUNT, RID_W and PAYLOAD_W for every user of this package.
package wired_lsu_oiq_pkg;

  localparam int OIQ_SRC_COUNT = 2;
  localparam int OIQ_RID_W     = 6;
  localparam int OIQ_PAYLOAD_W = 64;

  typedef struct packed {
    logic                 rdy;
    logic [OIQ_RID_W-1:0] rid;
    logic [31:0]          data;
  } lsu_oiq_src_t;

  typedef struct packed {
    logic                                valid;
    logic [OIQ_PAYLOAD_W-1:0]            payload;
    lsu_oiq_src_t [OIQ_SRC_COUNT-1:0]    src;
  } lsu_oiq_entry_t;

  function automatic logic rid_match(input logic                 cdb_valid,
                                     input logic [OIQ_RID_W-1:0] cdb_rid,
                                     input logic [OIQ_RID_W-1:0] src_rid);
    return cdb_valid && (cdb_rid == src_rid);
  endfunction

endpackage

// File: rtl/wired_lsu_oiq_slot.sv
// One issue-queue entry: write port, CDB snoop/capture for resident and incoming operands.
// With WIRED_LSU_OIQ_CDB_BYPASS_EN, entry_o shows the CDB-woken view of this cycle.
module wired_lsu_oiq_slot
  import wired_lsu_oiq_pkg::*;
#(
  parameter int CDB_COUNT = 2
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           flush,
  input  logic                           wr_en,
  input  lsu_oiq_entry_t                 wr_entry,
  input  logic                           clr,
  input  logic [CDB_COUNT-1:0]           cdb_valid,
  input  logic [CDB_COUNT*OIQ_RID_W-1:0] cdb_rid,
  input  logic [CDB_COUNT*32-1:0]        cdb_data,
  output lsu_oiq_entry_t                 entry_o
);

  lsu_oiq_entry_t entry_reg;
  lsu_oiq_entry_t entry_woken;
  lsu_oiq_entry_t wr_woken;

  // Descending scan so the lowest-index CDB hit is the one that sticks.
  always_comb begin
    entry_woken = entry_reg;
    wr_woken    = wr_entry;
    for (int s = 0; s < OIQ_SRC_COUNT; s++) begin
      for (int c = CDB_COUNT - 1; c >= 0; c--) begin
        if (!entry_reg.src[s].rdy &&
            rid_match(cdb_valid[c], cdb_rid[c*OIQ_RID_W +: OIQ_RID_W], entry_reg.src[s].rid)) begin
          entry_woken.src[s].rdy  = 1'b1;
          entry_woken.src[s].data = cdb_data[c*32 +: 32];
        end
        if (!wr_entry.src[s].rdy &&
            rid_match(cdb_valid[c], cdb_rid[c*OIQ_RID_W +: OIQ_RID_W], wr_entry.src[s].rid)) begin
          wr_woken.src[s].rdy  = 1'b1;
          wr_woken.src[s].data = cdb_data[c*32 +: 32];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      entry_reg <= '0;
    end else if (flush) begin
      entry_reg.valid <= 1'b0;
    end else if (wr_en) begin
      entry_reg <= wr_woken;
    end else if (clr) begin
      entry_reg.valid <= 1'b0;
    end else begin
      entry_reg <= entry_woken;
    end
  end

`ifdef WIRED_LSU_OIQ_CDB_BYPASS_EN
  assign entry_o = entry_woken;
`else
  assign entry_o = entry_reg;
`endif

endmodule

// File: rtl/wired_lsu_oiq.sv
// In-order LSU issue queue: compacted multi-slot enqueue at tail, head-only issue.
// Optional same-cycle CDB wakeup of the head via WIRED_LSU_OIQ_CDB_BYPASS_EN.
module wired_lsu_oiq
  import wired_lsu_oiq_pkg::*;
#(
  parameter int IQ_SIZE   = 8,
  parameter int DISP_W    = 2,
  parameter int CDB_COUNT = 2,
  parameter int SRC_COUNT = OIQ_SRC_COUNT,
  parameter int RID_W     = OIQ_RID_W,
  parameter int PAYLOAD_W = OIQ_PAYLOAD_W
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              flush_i,
  input  logic [DISP_W-1:0]                 p_valid_i,
  output logic                              p_ready_o,
  input  logic [DISP_W*PAYLOAD_W-1:0]       p_payload_i,
  input  logic [DISP_W*SRC_COUNT-1:0]       p_src_rdy_i,
  input  logic [DISP_W*SRC_COUNT*RID_W-1:0] p_src_rid_i,
  input  logic [DISP_W*SRC_COUNT*32-1:0]    p_src_data_i,
  input  logic [CDB_COUNT-1:0]              cdb_valid_i,
  input  logic [CDB_COUNT*RID_W-1:0]        cdb_rid_i,
  input  logic [CDB_COUNT*32-1:0]           cdb_data_i,
  output logic                              iss_valid_o,
  input  logic                              iss_ready_i,
  output logic [PAYLOAD_W-1:0]              iss_payload_o,
  output logic [SRC_COUNT*32-1:0]           iss_data_o,
  output logic [$clog2(IQ_SIZE):0]          count_o
);

  localparam int PTR_W = $clog2(IQ_SIZE);
  localparam int CNT_W = PTR_W + 1;
  localparam int OFF_W = $clog2(DISP_W) + 1;

  logic [PTR_W-1:0] head_reg, head_next;
  logic [PTR_W-1:0] tail_reg, tail_next;
  logic [CNT_W-1:0] count_reg, count_next;
  logic             p_ready_reg, p_ready_next;

  lsu_oiq_entry_t   disp_entry [DISP_W];
  logic [PTR_W-1:0] wr_idx     [DISP_W];
  logic [OFF_W-1:0] n_enq;
  logic             enq;
  logic             fire;
  logic             head_all_rdy;
  logic             head_rid_unused;

  logic [IQ_SIZE-1:0] wr_en;
  logic [IQ_SIZE-1:0] clr;
  lsu_oiq_entry_t     wr_entry  [IQ_SIZE];
  lsu_oiq_entry_t     slot_view [IQ_SIZE];
  lsu_oiq_entry_t     head_view;

  assign enq = p_ready_reg && (|p_valid_i) && !flush_i;

  // Prefix popcount: each valid slot lands at tail + (valid slots before it).
  always_comb begin
    n_enq = '0;
    for (int d = 0; d < DISP_W; d++) begin
      wr_idx[d]             = tail_reg + PTR_W'(n_enq);
      n_enq                 = n_enq + OFF_W'(p_valid_i[d]);
      disp_entry[d]         = '0;
      disp_entry[d].valid   = 1'b1;
      disp_entry[d].payload = p_payload_i[d*PAYLOAD_W +: PAYLOAD_W];
      for (int s = 0; s < SRC_COUNT; s++) begin
        disp_entry[d].src[s].rdy  = p_src_rdy_i[d*SRC_COUNT + s];
        disp_entry[d].src[s].rid  = p_src_rid_i[(d*SRC_COUNT + s)*RID_W +: RID_W];
        disp_entry[d].src[s].data = p_src_data_i[(d*SRC_COUNT + s)*32 +: 32];
      end
    end
  end

  always_comb begin
    wr_en = '0;
    for (int i = 0; i < IQ_SIZE; i++) begin
      wr_entry[i] = '0;
    end
    for (int d = 0; d < DISP_W; d++) begin
      if (enq && p_valid_i[d]) begin
        wr_en[wr_idx[d]]    = 1'b1;
        wr_entry[wr_idx[d]] = disp_entry[d];
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < IQ_SIZE; gi++) begin : g_slot
      assign clr[gi] = fire && (head_reg == PTR_W'(gi));

      wired_lsu_oiq_slot #(
        .CDB_COUNT (CDB_COUNT)
      ) u_slot (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush_i),
        .wr_en     (wr_en[gi]),
        .wr_entry  (wr_entry[gi]),
        .clr       (clr[gi]),
        .cdb_valid (cdb_valid_i),
        .cdb_rid   (cdb_rid_i),
        .cdb_data  (cdb_data_i),
        .entry_o   (slot_view[gi])
      );
    end
  endgenerate

  assign head_view = slot_view[head_reg];

  always_comb begin
    head_all_rdy    = 1'b1;
    head_rid_unused = 1'b0;
    for (int s = 0; s < SRC_COUNT; s++) begin
      head_all_rdy    = head_all_rdy & head_view.src[s].rdy;
      head_rid_unused = head_rid_unused ^ (^head_view.src[s].rid);
    end
  end

  assign iss_valid_o   = !flush_i && head_view.valid && head_all_rdy;
  assign fire          = iss_valid_o && iss_ready_i;
  assign iss_payload_o = head_view.payload;

  generate
    for (gi = 0; gi < SRC_COUNT; gi++) begin : g_iss_data
      assign iss_data_o[gi*32 +: 32] = head_view.src[gi].data;
    end
  endgenerate

  // Ready looks only at next occupancy, so a dequeue never admits extra dispatch this cycle.
  always_comb begin
    head_next  = head_reg;
    tail_next  = tail_reg;
    count_next = count_reg;
    if (flush_i) begin
      head_next  = '0;
      tail_next  = '0;
      count_next = '0;
    end else begin
      if (enq) begin
        tail_next  = tail_reg + PTR_W'(n_enq);
        count_next = count_next + CNT_W'(n_enq);
      end
      if (fire) begin
        head_next  = head_reg + PTR_W'(1);
        count_next = count_next - CNT_W'(1);
      end
    end
    p_ready_next = (CNT_W'(IQ_SIZE) - count_next) >= CNT_W'(DISP_W);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_reg    <= '0;
      tail_reg    <= '0;
      count_reg   <= '0;
      p_ready_reg <= 1'b1;
    end else begin
      head_reg    <= head_next;
      tail_reg    <= tail_next;
      count_reg   <= count_next;
      p_ready_reg <= p_ready_next;
    end
  end

  assign p_ready_o = p_ready_reg;
  assign count_o   = count_reg;

endmodule
